req_arbiter: RTL and testbench

Sequential arbiter that shares one resource among eight requesters using an 8-to-3 priority encoder as its decision core. It supports fixed-priority and round-robin modes, holds a grant until the owner releases it or a hold limit expires, and drives the granted index onto a seven-segment digit for board display. It sits between the board switch/request inputs and whatever single-owner resource the lab design shares.

---
 rtl/arb_pkg.sv | 30 +++
 rtl/req_arbiter_if.sv | 23 ++
 rtl/prio_enc8.sv | 20 ++
 rtl/req_arbiter.sv | 86 ++++++++
 tb/tb_req_arbiter.sv | 129 ++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the eight-way request arbiter.
// Holds the FSM state type, sizing constants and the seven-segment lookup.
package arb_pkg;

  localparam int unsigned N   = 8;
  localparam int unsigned IDW = 3;

  typedef enum logic [0:0] {StIdle, StGrant} state_t;

  // Active-low {g,f,e,d,c,b,a}; blank when no grant is held.
  function automatic logic [6:0] seg_of(input logic [IDW-1:0] id, input logic vld);
    logic [6:0] seg;
    if (!vld) begin
      seg = 7'b1111111;
    end else begin
      unique case (id)
        3'd0:    seg = 7'b1000000;
        3'd1:    seg = 7'b1111001;
        3'd2:    seg = 7'b0100100;
        3'd3:    seg = 7'b0110000;
        3'd4:    seg = 7'b0011001;
        3'd5:    seg = 7'b0010010;
        3'd6:    seg = 7'b0000010;
        default: seg = 7'b1111000;
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the board inputs and the arbiter.
// The master drives requests and control; the slave returns the grant.
interface req_arbiter_if;

  logic                     en;
  logic                     mode;
  logic [arb_pkg::N-1:0]    req;
  logic [arb_pkg::N-1:0]    gnt;
  logic [arb_pkg::IDW-1:0]  gnt_id;
  logic                     gnt_vld;
  logic [6:0]               seg0;

  modport master (
    output en, mode, req,
    input  gnt, gnt_id, gnt_vld, seg0
  );

  modport slave (
    input  en, mode, req,
    output gnt, gnt_id, gnt_vld, seg0
  );

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the highest set index wins.
// o_any flags that at least one input bit is set.
module prio_enc8 (
  input  logic [7:0] i_req,
  output logic [2:0] o_idx,
  output logic       o_any
);

  always_comb begin
    o_idx = 3'd0;
    o_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i_req[i]) begin
        o_idx = i[2:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Eight-way fixed/round-robin arbiter with hold-until-release grants,
// a round-robin hold limit and a seven-segment readout of the owner.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic         i_clk,
  input  logic         i_rst,
  req_arbiter_if.slave bus
);

  localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);

  state_t           r_state;
  logic [N-1:0]     r_gnt;
  logic [IDW-1:0]   r_gnt_id;
  logic             r_gnt_vld;
  logic [IDW-1:0]   r_ptr;
  logic [7:0]       r_hold;

  logic [IDW-1:0]   w_ptr_eff;
  logic [IDW-1:0]   w_shift;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDW-1:0]   w_rot_idx;
  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic             w_release;

  // Rotate so the pointer position lands on bit 7, the encoder's top priority.
  assign w_ptr_eff = bus.mode ? r_ptr : 3'd7;
  assign w_shift   = w_ptr_eff + 3'd1;
  assign w_dbl     = {bus.req, bus.req} >> w_shift;
  assign w_rot     = w_dbl[N-1:0];
  assign w_win     = w_rot_idx + w_shift;

  prio_enc8 u_enc (
    .i_req (w_rot),
    .o_idx (w_rot_idx),
    .o_any (w_any)
  );

  assign w_release = !bus.en || !bus.req[r_gnt_id] || (bus.mode && (r_hold == HoldLimit));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
      r_ptr     <= 3'd7;
      r_hold    <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.en && w_any) begin
            r_state   <= StGrant;
            r_gnt     <= 8'b1 << w_win;
            r_gnt_id  <= w_win;
            r_gnt_vld <= 1'b1;
            r_hold    <= 8'd1;
            r_ptr     <= w_win - 3'd1;
          end
        end
        default: begin
          if (w_release) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_gnt_vld <= 1'b0;
            r_hold    <= 8'd0;
          end else if (r_hold != 8'hFF) begin
            r_hold    <= r_hold + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.seg0    = seg_of(r_gnt_id, r_gnt_vld);

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: each step queues the expected outputs
// for the next edge and checks them against the DUT after that edge.
module tb_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  req_arbiter_if bus ();

  req_arbiter #(
    .MAX_HOLD (3)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic v, input logic [2:0] id);
    if (!v) return 7'b1111111;
    case (id)
      3'd0: return 7'b1000000;
      3'd1: return 7'b1111001;
      3'd2: return 7'b0100100;
      3'd3: return 7'b0110000;
      3'd4: return 7'b0011001;
      3'd5: return 7'b0010010;
      3'd6: return 7'b0000010;
      default: return 7'b1111000;
    endcase
  endfunction

  task automatic chk(input string tag, input string what, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus; v/id describe the outputs after the next edge.
  task automatic cyc(input string tag, input logic r, input logic e, input logic m,
                     input logic [7:0] rq, input logic v, input logic [2:0] id);
    exp_t x;
    rst      = r;
    bus.en   = e;
    bus.mode = m;
    bus.req  = rq;
    x.tag = tag;
    x.vld = v;
    x.id  = v ? id : 3'd0;
    x.gnt = v ? (8'b1 << id) : 8'h00;
    x.seg = model_seg(v, id);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk(x.tag, "gnt", bus.gnt, x.gnt);
    chk(x.tag, "gnt_id", {5'd0, bus.gnt_id}, {5'd0, x.id});
    chk(x.tag, "gnt_vld", {7'd0, bus.gnt_vld}, {7'd0, x.vld});
    chk(x.tag, "seg0", {1'b0, bus.seg0}, {1'b0, x.seg});
  endtask

  // Three-cycle round-robin grant to k followed by the mandatory idle cycle.
  task automatic rr_grant(input string tag, input logic [7:0] rq, input logic [2:0] k);
    for (int c = 0; c < 3; c++) cyc(tag, 1'b0, 1'b1, 1'b1, rq, 1'b1, k);
    cyc(tag, 1'b0, 1'b1, 1'b1, rq, 1'b0, 3'd0);
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.mode = 1'b0;
    bus.req  = 8'h00;

    cyc("reset", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) cyc("req_zero", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);

    // Fixed priority: highest index, no preemption, release then re-arbitrate.
    cyc("fix_win5", 1'b0, 1'b1, 1'b0, 8'b0010_0110, 1'b1, 3'd5);
    cyc("fix_hold5", 1'b0, 1'b1, 1'b0, 8'b0010_0110, 1'b1, 3'd5);
    cyc("fix_rel5", 1'b0, 1'b1, 1'b0, 8'b0000_0110, 1'b0, 3'd0);
    cyc("fix_win2", 1'b0, 1'b1, 1'b0, 8'b0000_0110, 1'b1, 3'd2);
    cyc("fix_nopre", 1'b0, 1'b1, 1'b0, 8'b0000_1100, 1'b1, 3'd2);
    cyc("fix_rel2", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    cyc("fix_idle", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);

    // Round robin, all requesting, hold limit 3: 7 down to 0 then wrap to 7.
    cyc("rr_rst", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0);
    for (int k = 7; k >= 0; k--) rr_grant("rr_all", 8'hFF, 3'(k));
    rr_grant("rr_wrap", 8'hFF, 3'd7);

    // Fairness between the two extreme requesters.
    cyc("fair_rst", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0);
    rr_grant("fair", 8'b1000_0001, 3'd7);
    rr_grant("fair", 8'b1000_0001, 3'd0);
    rr_grant("fair", 8'b1000_0001, 3'd7);
    rr_grant("fair", 8'b1000_0001, 3'd0);

    // Enable low releases an active grant and blocks new ones.
    cyc("en_rst", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    cyc("en_win3", 1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 3'd3);
    cyc("en_drop", 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) cyc("en_low", 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 3'd0);

    // Reset mid-grant restores the pointer: 8'h11 must go to 4, not 0.
    cyc("mid_rst0", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0);
    cyc("mid_win4", 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 3'd4);
    cyc("mid_rst", 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 3'd0);
    cyc("mid_after", 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 3'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
